if_fetch_queue: RTL and testbench

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

---
 rtl/fetch_pkg.sv | 15 +
 rtl/if_fetch_queue.sv | 113 +++++++++++
 tb/tb_if_fetch_queue.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch queue.
// A slot carries the fetch PC, its PC+4, the returned instruction and a filled flag.
package fetch_pkg;

    localparam int FETCH_WIDTH = 32;
    localparam int FETCH_DEPTH = 4;

    typedef struct packed {
        logic [FETCH_WIDTH-1:0] pc;
        logic [FETCH_WIDTH-1:0] pcplus4;
        logic [FETCH_WIDTH-1:0] instr;
        logic                   filled;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue.sv
// Decouples PC generation from an in-order, fixed-order instruction memory.
// Slot fields are sized by fetch_pkg, so WIDTH is expected to stay at FETCH_WIDTH.
module if_fetch_queue
    import fetch_pkg::*;
#(
    parameter int WIDTH = FETCH_WIDTH,
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] PCF,
    input  logic [WIDTH-1:0] PCPlus4F,
    output logic             en,
    input  logic             FlushF,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_resp_valid,
    input  logic [WIDTH-1:0] imem_resp_data,
    output logic             InstrValidF,
    input  logic             InstrReadyD,
    output logic [WIDTH-1:0] InstrF,
    output logic [WIDTH-1:0] PCOutF,
    output logic [WIDTH-1:0] PCPlus4OutF
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int DW = IW + 2;

    fetch_entry_t  r_slots [DEPTH];
    logic [PW-1:0] r_alloc;
    logic [PW-1:0] r_fill;
    logic [PW-1:0] r_read;
    logic [DW-1:0] r_drop_cnt;

    logic [PW-1:0] w_occupancy;
    logic [PW-1:0] w_pending;
    logic          w_full;
    logic          w_resp_keep;
    logic          w_resp_drop;
    logic          w_pop;
    logic          w_flush_resp;
    logic [DW-1:0] w_flush_drop;
    fetch_entry_t  w_head;

    assign w_occupancy = r_alloc - r_read;
    assign w_pending   = r_alloc - r_fill;
    assign w_full      = (w_occupancy == PW'(DEPTH));

    assign imem_req_valid = !rst && !FlushF && !w_full;
    assign en             = imem_req_valid && imem_req_ready;
    assign imem_req_addr  = PCF;

    // A response belongs to a live slot only when no stale fetches are still owed.
    assign w_resp_keep = imem_resp_valid && !FlushF && (r_drop_cnt == '0) && (w_pending != '0);
    assign w_resp_drop = imem_resp_valid && !FlushF && (r_drop_cnt != '0);

    // Everything still outstanding becomes stale on a redirect; a response landing
    // in the redirect cycle retires one of those stale fetches immediately.
    assign w_flush_resp = imem_resp_valid && ((r_drop_cnt != '0) || (w_pending != '0));
    assign w_flush_drop = r_drop_cnt + DW'(w_pending) - DW'(w_flush_resp);

    assign w_head      = r_slots[r_read[IW-1:0]];
    assign InstrValidF = !rst && (w_occupancy != '0) && w_head.filled;
    assign w_pop       = InstrValidF && InstrReadyD && !FlushF;

    assign InstrF      = rst ? '0 : w_head.instr;
    assign PCOutF      = rst ? '0 : w_head.pc;
    assign PCPlus4OutF = rst ? '0 : w_head.pcplus4;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alloc    <= '0;
            r_fill     <= '0;
            r_read     <= '0;
            r_drop_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_slots[i] <= '0;
            end
        end else if (FlushF) begin
            r_alloc    <= '0;
            r_fill     <= '0;
            r_read     <= '0;
            r_drop_cnt <= w_flush_drop;
            for (int i = 0; i < DEPTH; i++) begin
                r_slots[i].filled <= 1'b0;
            end
        end else begin
            // Accept and fill never target the same slot: that would need pending==DEPTH,
            // which implies a full queue and therefore no accept.
            if (en) begin
                r_slots[r_alloc[IW-1:0]].pc      <= PCF;
                r_slots[r_alloc[IW-1:0]].pcplus4 <= PCPlus4F;
                r_slots[r_alloc[IW-1:0]].instr   <= '0;
                r_slots[r_alloc[IW-1:0]].filled  <= 1'b0;
                r_alloc <= r_alloc + 1'b1;
            end
            if (w_resp_keep) begin
                r_slots[r_fill[IW-1:0]].instr  <= imem_resp_data;
                r_slots[r_fill[IW-1:0]].filled <= 1'b1;
                r_fill <= r_fill + 1'b1;
            end
            if (w_resp_drop) begin
                r_drop_cnt <= r_drop_cnt - 1'b1;
            end
            if (w_pop) begin
                r_read <= r_read + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue against a queue-level reference model
// with an in-order, variable-latency instruction memory model.
module tb_if_fetch_queue;
    import fetch_pkg::*;

    localparam int W = 32;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] PCF = '0;
    logic [W-1:0] PCPlus4F = '0;
    logic         en;
    logic         FlushF = 1'b0;
    logic         imem_req_valid;
    logic         imem_req_ready = 1'b0;
    logic [W-1:0] imem_req_addr;
    logic         imem_resp_valid = 1'b0;
    logic [W-1:0] imem_resp_data = '0;
    logic         InstrValidF;
    logic         InstrReadyD = 1'b0;
    logic [W-1:0] InstrF;
    logic [W-1:0] PCOutF;
    logic [W-1:0] PCPlus4OutF;

    always #5 clk = ~clk;

    if_fetch_queue #(.WIDTH(W), .DEPTH(D)) dut (
        .clk             (clk),
        .rst             (rst),
        .PCF             (PCF),
        .PCPlus4F        (PCPlus4F),
        .en              (en),
        .FlushF          (FlushF),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .InstrValidF     (InstrValidF),
        .InstrReadyD     (InstrReadyD),
        .InstrF          (InstrF),
        .PCOutF          (PCOutF),
        .PCPlus4OutF     (PCPlus4OutF)
    );

    typedef struct {
        logic [W-1:0] pc;
        logic [W-1:0] instr;
    } ent_t;

    typedef struct {
        logic [W-1:0] addr;
        int           due;
    } mreq_t;

    // Reference model: fetched-but-unconsumed entries in program order, the first
    // n_filled of which have their instruction; drop counts stale responses owed.
    ent_t   q[$];
    int     n_filled = 0;
    int     drop = 0;
    mreq_t  mq[$];
    logic [W-1:0] pc = '0;
    int     cyc = 0;

    int n_tests = 0;
    int n_fail  = 0;

    int p_ready  = 100;
    int p_readyd = 100;
    int p_flush  = 0;
    int lat_lo   = 1;
    int lat_hi   = 1;
    bit force_flush = 1'b0;

    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic run_cycle(input bit do_rst);
        bit           flush;
        bit           rdy;
        bit           rdyd;
        bit           resp;
        bit           exp_req;
        bit           exp_en;
        bit           exp_iv;
        logic [W-1:0] rdata;
        ent_t         e;
        mreq_t        m;

        @(negedge clk);
        flush = !do_rst && (force_flush || ($urandom_range(99) < p_flush));
        rdy   = ($urandom_range(99) < p_ready);
        rdyd  = ($urandom_range(99) < p_readyd);
        resp  = !do_rst && (mq.size() > 0) && (mq[0].due <= cyc);
        rdata = resp ? mem_word(mq[0].addr) : $urandom;

        rst             = do_rst;
        FlushF          = flush;
        PCF             = pc;
        PCPlus4F        = pc + 4;
        imem_req_ready  = rdy;
        imem_resp_valid = resp;
        imem_resp_data  = rdata;
        InstrReadyD     = rdyd;
        #1;

        exp_req = !do_rst && !flush && (q.size() < D);
        exp_en  = exp_req && rdy;
        exp_iv  = !do_rst && (n_filled > 0);

        check_eq("req_valid", imem_req_valid, exp_req);
        check_eq("en", en, exp_en);
        check_eq("instr_valid", InstrValidF, exp_iv);
        if (do_rst) begin
            check_eq("rst_instr", InstrF, 0);
            check_eq("rst_pc", PCOutF, 0);
            check_eq("rst_pcplus4", PCPlus4OutF, 0);
        end
        if (exp_req) begin
            check_eq("req_addr", imem_req_addr, pc);
        end
        if (exp_iv) begin
            check_eq("head_pc", PCOutF, q[0].pc);
            check_eq("head_pcplus4", PCPlus4OutF, q[0].pc + 4);
            check_eq("head_instr", InstrF, q[0].instr);
        end

        if (do_rst) begin
            q.delete();
            mq.delete();
            n_filled = 0;
            drop = 0;
            pc = '0;
        end else begin
            if (resp) void'(mq.pop_front());
            if (flush) begin
                drop += q.size() - n_filled;
                if (resp && drop > 0) drop--;
                q.delete();
                n_filled = 0;
                pc = $urandom & 32'h0000_FFFC;
                $display("[TB] cyc=%0d flush drop=%0d new_pc=%0h", cyc, drop, pc);
            end else begin
                if (resp) begin
                    if (drop > 0) drop--;
                    else if (n_filled < q.size()) begin
                        q[n_filled].instr = rdata;
                        n_filled++;
                    end
                end
                if (exp_iv && rdyd) begin
                    e = q.pop_front();
                    n_filled--;
                    $display("[TB] cyc=%0d pop pc=%0h instr=%0h", cyc, e.pc, e.instr);
                end
                if (exp_en) begin
                    e.pc = pc;
                    e.instr = '0;
                    q.push_back(e);
                    m.addr = pc;
                    m.due  = cyc + $urandom_range(lat_hi, lat_lo);
                    mq.push_back(m);
                    pc = pc + 4;
                end
            end
        end
        cyc++;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0);
    endtask

    initial begin
        run_cycle(1'b1);
        run_cycle(1'b1);

        // streaming with one-cycle memory and an always-ready decoder
        cyc = 0;
        run_cycles(8);

        // decoder stalls until the queue fills, then releases
        p_readyd = 0;
        run_cycles(6);
        p_readyd = 100;
        run_cycles(4);

        // redirect with two fetches in flight behind a three-cycle memory
        lat_lo = 3; lat_hi = 3;
        run_cycle(1'b1);
        run_cycles(2);
        force_flush = 1'b1; run_cycle(1'b0); force_flush = 1'b0;
        run_cycles(10);

        // redirect in the same cycle as a response, with two pending
        lat_lo = 2; lat_hi = 2;
        run_cycles(5);
        force_flush = 1'b1; run_cycle(1'b0); force_flush = 1'b0;
        run_cycles(8);

        // memory accept toggling
        lat_lo = 1; lat_hi = 2; p_ready = 50;
        run_cycles(20);
        p_ready = 100;

        // reset with three entries queued
        lat_lo = 1; lat_hi = 1; p_readyd = 0;
        run_cycle(1'b1);
        run_cycles(3);
        run_cycle(1'b1);
        run_cycle(1'b1);
        p_readyd = 100;
        run_cycles(4);

        // random mix
        p_ready = 70; p_readyd = 60; p_flush = 5; lat_lo = 1; lat_hi = 4;
        run_cycles(600);

        p_ready = 100; p_readyd = 100; p_flush = 0;
        run_cycles(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
